// File: rtl/spi_slave_tx.sv
// spi_slave_tx - SPI mode-0 slave transmit serializer.
//
// Pops DW-bit words from a first-word-fall-through TX FIFO and shifts them
// out on MISO while an external master clocks SCLK. SCLK and CS_n are
// asynchronous and are oversampled in the HCLK domain.
//
// Optional build macro: SPI_TX_LSB_FIRST_EN
//   defined   -> each word is sent LSB first (shift right, MISO = shift_reg[0])
//   undefined -> each word is sent MSB first (default)
//
// Ports:
//   HCLK, HRESETn   system clock (rising edge), async active-low reset
//   spi_sclk        SPI clock from master (CPOL=0), asynchronous
//   spi_cs_n        SPI chip select, active-low, asynchronous
//   spi_miso        registered serial data out (0 while not driven)
//   spi_miso_oe     MISO output enable, high while selected
//   tx_fifo_empty   FIFO empty flag
//   tx_fifo_dout    FIFO head word
//   tx_fifo_rd_en   one-cycle pop strobe
//   tx_underrun     one-cycle pulse when IDLE_PATTERN is loaded instead of data
//   busy            high whenever the FSM is not idle
//
// state | meaning
// IDLE  | not selected, waiting for CS fall
// LOAD  | one cycle: load first word of the frame
// SHIFT | shift one bit per SCLK fall, reload at word boundary

module spi_slave_tx #(
    parameter int unsigned          DW           = 32,
    parameter int unsigned          SYNC_STAGES  = 2,
    parameter logic [DW-1:0]        IDLE_PATTERN = '0
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          spi_sclk,
    input  logic          spi_cs_n,
    output logic          spi_miso,
    output logic          spi_miso_oe,
    input  logic          tx_fifo_empty,
    input  logic [DW-1:0] tx_fifo_dout,
    output logic          tx_fifo_rd_en,
    output logic          tx_underrun,
    output logic          busy
);

    localparam int unsigned    CW   = $clog2(DW);
    localparam logic [CW-1:0]  LAST = CW'(DW - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t               state, state_next;
    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync;
    logic                 sclk_prev, cs_prev;
    logic                 sclk_cur, cs_cur;
    logic                 sclk_fall, cs_fall, cs_rise;
    logic [DW-1:0]        shift_reg, shift_next;
    logic [CW-1:0]        bit_cnt;
    logic                 do_load, do_shift;
    logic                 out_bit;

    // Synchronizers reset to the idle bus levels so that releasing reset
    // never fabricates an edge.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            sclk_prev <= sclk_cur;
            cs_prev   <= cs_cur;
        end
    end

    assign sclk_cur  = sclk_sync[SYNC_STAGES-1];
    assign cs_cur    = cs_sync[SYNC_STAGES-1];
    assign sclk_fall = sclk_prev & ~sclk_cur;
    assign cs_fall   = cs_prev & ~cs_cur;
    assign cs_rise   = ~cs_prev & cs_cur;

`ifdef SPI_TX_LSB_FIRST_EN
    assign shift_next = {1'b0, shift_reg[DW-1:1]};
    assign out_bit    = shift_reg[0];
`else
    assign shift_next = {shift_reg[DW-2:0], 1'b0};
    assign out_bit    = shift_reg[DW-1];
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // cs_rise is tested first so a coincident SCLK fall never loads or pops.
    always_comb begin
        state_next = state;
        do_load    = 1'b0;
        do_shift   = 1'b0;
        unique case (state)
            IDLE: begin
                if (cs_fall) state_next = LOAD;
            end
            LOAD: begin
                if (cs_rise) begin
                    state_next = IDLE;
                end else begin
                    do_load    = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_next = IDLE;
                end else if (sclk_fall) begin
                    if (bit_cnt == LAST) do_load  = 1'b1;
                    else                 do_shift = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign tx_fifo_rd_en = do_load & ~tx_fifo_empty;
    assign tx_underrun   = do_load & tx_fifo_empty;
    assign busy          = (state != IDLE);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            shift_reg   <= '0;
            bit_cnt     <= '0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
        end else begin
            if (do_load) begin
                shift_reg <= tx_fifo_empty ? IDLE_PATTERN : tx_fifo_dout;
                bit_cnt   <= '0;
            end else if (do_shift) begin
                shift_reg <= shift_next;
                bit_cnt   <= bit_cnt + 1'b1;
            end
            // MISO is held low in the LOAD cycle so the stale register
            // content never reaches the pin before the first real bit.
            spi_miso_oe <= (state != IDLE);
            spi_miso    <= (state == SHIFT) ? out_bit : 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_slave_tx.sv
module tb_spi_slave_tx;

    localparam int SS = 2;      // synchronizer depth of the DUT
    localparam int H  = 6;      // SCLK half period in HCLK cycles

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        spi_sclk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_miso, spi_miso_oe;
    logic        tx_fifo_empty;
    logic [31:0] tx_fifo_dout;
    logic        tx_fifo_rd_en, tx_underrun, busy;

    spi_slave_tx #(.DW(32), .SYNC_STAGES(SS), .IDLE_PATTERN(32'h0)) dut (
        .HCLK          (HCLK),
        .HRESETn       (HRESETn),
        .spi_sclk      (spi_sclk),
        .spi_cs_n      (spi_cs_n),
        .spi_miso      (spi_miso),
        .spi_miso_oe   (spi_miso_oe),
        .tx_fifo_empty (tx_fifo_empty),
        .tx_fifo_dout  (tx_fifo_dout),
        .tx_fifo_rd_en (tx_fifo_rd_en),
        .tx_underrun   (tx_underrun),
        .busy          (busy)
    );

    always #5 HCLK = ~HCLK;

    // FIFO model
    logic [31:0] mem [0:255];
    int rd_ptr = 0;
    int wr_ptr = 0;
    assign tx_fifo_empty = (rd_ptr == wr_ptr);
    assign tx_fifo_dout  = mem[rd_ptr[7:0]];

    int cyc = 0;
    int und_cnt = 0;
    int bad_pop = 0;
    int pop_cyc[$];

    always @(posedge HCLK) begin
        cyc <= cyc + 1;
        if (tx_fifo_rd_en) begin
            if (tx_fifo_empty) bad_pop <= bad_pop + 1;
            rd_ptr <= rd_ptr + 1;
            pop_cyc.push_back(cyc);
        end
        if (tx_underrun) und_cnt <= und_cnt + 1;
    end

    int vectors = 0;
    int miscompares = 0;
    logic rx[$];
    int fall32;
    int pops0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge HCLK);
    endtask

    task automatic push(input logic [31:0] w);
        mem[wr_ptr[7:0]] = w;
        wr_ptr++;
    endtask

    // Portion of a word the master should see after m bits, packed in arrival order.
    function automatic logic [63:0] exp_bits(input logic [31:0] w, input int m);
        logic [63:0] wide;
        wide = {32'h0, w};
`ifdef SPI_TX_LSB_FIRST_EN
        return wide & ((64'h1 << m) - 64'h1);
`else
        return wide >> (32 - m);
`endif
    endfunction

    function automatic logic [63:0] pack_bits(input int first, input int m);
        logic [63:0] got;
        got = '0;
        for (int j = 0; j < m; j++) begin
`ifdef SPI_TX_LSB_FIRST_EN
            got = got | ({63'h0, rx[first + j]} << j);
`else
            got = {got[62:0], rx[first + j]};
`endif
        end
        return got;
    endfunction

    // Mode-0 master: drive on fall, sample on rise. The last SCLK fall and the
    // CS rise are driven together.
    task automatic frame(input int n, input int push_at, input logic [31:0] push_val,
                         input int reset_at);
        rx.delete();
        fall32 = -1;
        spi_cs_n = 1'b0;
        wait_cyc(H);
        if (n == 0) spi_cs_n = 1'b1;
        for (int i = 0; i < n; i++) begin
            spi_sclk = 1'b1;
            rx.push_back(spi_miso);
            chk("oe_in_frame", {63'h0, spi_miso_oe}, 64'h1);
            chk("busy_in_frame", {63'h0, busy}, 64'h1);
            if (i == reset_at) begin
                HRESETn = 1'b0;
                #1;
                chk("reset_mid_outputs",
                    {59'h0, spi_miso, spi_miso_oe, tx_fifo_rd_en, tx_underrun, busy}, 64'h0);
                spi_sclk = 1'b0;
                spi_cs_n = 1'b1;
                wait_cyc(3);
                HRESETn = 1'b1;
                wait_cyc(3);
                return;
            end
            wait_cyc(H);
            spi_sclk = 1'b0;
            if (i == n - 1) spi_cs_n = 1'b1;
            if (i == 31) fall32 = cyc;
            if (i == push_at) push(push_val);
            wait_cyc(H);
        end
        wait_cyc(10);
        chk("idle_after_frame", {61'h0, spi_miso_oe, spi_miso, busy}, 64'h0);
    endtask

    task automatic run_frame(input int n, input int push_at, input logic [31:0] push_val);
        logic [31:0] q[$];
        logic [31:0] words[$];
        int loads, exp_pops, exp_und, und0, m;
        for (int p = rd_ptr; p < wr_ptr; p++) q.push_back(mem[p[7:0]]);
        loads = (n == 0) ? 1 : 1 + (n - 1) / 32;
        exp_pops = 0;
        exp_und = 0;
        for (int i = 0; i < loads; i++) begin
            if (i == 1 && push_at >= 0) q.push_back(push_val);
            if (q.size() > 0) begin
                words.push_back(q.pop_front());
                exp_pops++;
            end else begin
                words.push_back(32'h0);
                exp_und++;
            end
        end
        und0  = und_cnt;
        pops0 = pop_cyc.size();
        frame(n, push_at, push_val, -1);
        for (int w = 0; w < words.size(); w++) begin
            m = n - 32 * w;
            if (m > 32) m = 32;
            if (m > 0) chk("rx_word", pack_bits(32 * w, m), exp_bits(words[w], m));
        end
        chk("pop_count", 64'(pop_cyc.size() - pops0), 64'(exp_pops));
        chk("underrun_count", 64'(und_cnt - und0), 64'(exp_und));
        chk("no_pop_when_empty", 64'(bad_pop), 64'h0);
    endtask

    initial begin
        int und0, nw, nb;
        wait_cyc(3);
        chk("reset_outputs",
            {59'h0, spi_miso, spi_miso_oe, tx_fifo_rd_en, tx_underrun, busy}, 64'h0);
        HRESETn = 1'b1;
        wait_cyc(4);

        push(32'hA5C3_0F81);
        run_frame(32, -1, 32'h0);

        push(32'h1234_5678);
        push(32'hDEAD_BEEF);
        run_frame(64, -1, 32'h0);
        if (pop_cyc.size() >= pops0 + 2)
            chk("second_pop_timing", 64'(pop_cyc[pops0 + 1]), 64'(fall32 + SS));
        else
            chk("second_pop_seen", 64'(pop_cyc.size() - pops0), 64'h2);

        run_frame(32, -1, 32'h0);

        push(32'hFFFF_0000);
        push(32'h0000_FFFF);
        run_frame(10, -1, 32'h0);
        run_frame(32, -1, 32'h0);

        push(32'h1357_9BDF);
        push(32'h2468_ACE0);
        pops0 = pop_cyc.size();
        und0  = und_cnt;
        frame(40, -1, 32'h0, 17);
        chk("reset_frame_bits", pack_bits(0, 18), exp_bits(32'h1357_9BDF, 18));
        chk("reset_frame_pops", 64'(pop_cyc.size() - pops0), 64'h1);
        chk("reset_frame_und", 64'(und_cnt - und0), 64'h0);
        run_frame(32, -1, 32'h0);

        run_frame(64, 5, 32'hCAFE_F00D);

        push(32'h0000_0001);
        run_frame(32, -1, 32'h0);

        push(32'h0BAD_CAFE);
        run_frame(0, -1, 32'h0);

        for (int k = 0; k < 5; k++) begin
            nw = int'($urandom_range(0, 3));
            for (int j = 0; j < nw; j++) push($urandom);
            nb = int'($urandom_range(1, 80));
            run_frame(nb, -1, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
